// File: rtl/cpu_trace_pkg.sv
// Shared constants for the retire-trace buffer: FSM encoding, entry width
// and the field offsets used to slice rd_data.
package cpu_trace_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] POST  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int TRACE_W = 32;

    function automatic int entry_width(input int w);
        return 3 * w + 6;
    endfunction

    localparam int ENTRY_W = 3 * TRACE_W + 6;

    // Entry layout {pc, instr, regwrite, wreg, wdata}, pc in the MSBs.
    localparam int WDATA_LSB    = 0;
    localparam int WREG_LSB     = TRACE_W;
    localparam int REGWRITE_BIT = TRACE_W + 5;
    localparam int INSTR_LSB    = TRACE_W + 6;
    localparam int PC_LSB       = 2 * TRACE_W + 6;

endpackage

// File: rtl/trace_ram.sv
// Flop-array trace storage: one synchronous write port, one asynchronous
// read port so the oldest entry is visible with zero latency.
module trace_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 102
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retire-trace capture for the single-cycle MIPS CPU: circular capture until a
// PC-match trigger plus post-trigger entries, then oldest-first drain.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [W-1:0]             pc,
    input  logic [W-1:0]             instr,
    input  logic                     regwrite,
    input  logic [4:0]               wreg,
    input  logic [W-1:0]             wdata,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [W-1:0]             trig_pc,
    input  logic [PTR_W-1:0]         post_count,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [3*W+5:0]           rd_data,
    output logic [PTR_W:0]           count,
    output logic                     wrapped,
    output logic [1:0]               state
);

    localparam int             ENTRY_W   = entry_width(W);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] POST_MAX = (PTR_W)'(DEPTH - 1);

    logic [1:0]       next_state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] post_left;
    logic [PTR_W-1:0] post_clamped;
    logic             capture;
    logic             trig_hit;
    logic             pop;
    logic             full;

    // Arm in the same cycle drops any capture and wins over a pop.
    assign capture  = en && !arm && ((state == ARMED) || (state == POST));
    assign trig_hit = capture && (state == ARMED) && trig_en && (pc == trig_pc);
    assign pop      = (state == DONE) && (count != '0) && rd_ready && !arm;
    assign full     = (count == DEPTH_CNT);

    // Keeps the trigger entry inside the window for any post_count.
    assign post_clamped = ({1'b0, post_count} >= DEPTH_CNT) ? POST_MAX : post_count;

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata ({pc, instr, regwrite, wreg, wdata}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (arm) next_state = ARMED;
            end
            ARMED: begin
                if (arm) begin
                    next_state = ARMED;
                end else if (trig_hit) begin
                    next_state = (post_clamped == '0) ? DONE : POST;
                end
            end
            POST: begin
                if (arm) begin
                    next_state = ARMED;
                end else if (capture && (post_left == PTR_W'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (arm) begin
                    next_state = ARMED;
                end else if (pop && (count == (PTR_W + 1)'(1))) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_valid = (state == DONE) && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_left <= '0;
            wrapped   <= 1'b0;
        end else if (arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_left <= '0;
            wrapped   <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                // A full buffer overwrites its oldest entry.
                if (full) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    wrapped <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (trig_hit) begin
                post_left <= post_clamped;
            end else if (capture && (state == POST)) begin
                post_left <= post_left - 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=8): capture, wrap, post-trigger,
// back-pressure, restart/reset and gap scenarios with hand-computed results.
module tb_cpu_trace_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [W-1:0]     pc;
    logic [W-1:0]     instr;
    logic             regwrite;
    logic [4:0]       wreg;
    logic [W-1:0]     wdata;
    logic             arm;
    logic             trig_en;
    logic [W-1:0]     trig_pc;
    logic [PTR_W-1:0] post_count;
    logic             rd_valid;
    logic             rd_ready;
    logic [3*W+5:0]   rd_data;
    logic [PTR_W:0]   count;
    logic             wrapped;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    cpu_trace_buffer #(.W(W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pc         (pc),
        .instr      (instr),
        .regwrite   (regwrite),
        .wreg       (wreg),
        .wdata      (wdata),
        .arm        (arm),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .count      (count),
        .wrapped    (wrapped),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_retire(input logic [W-1:0] p);
        en       = 1'b1;
        pc       = p;
        instr    = ~p;
        regwrite = p[2];
        wreg     = p[6:2];
        wdata    = p * 3;
    endtask

    task automatic retire(input logic [W-1:0] p);
        set_retire(p);
        tick();
        en = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rd_pc();
        return rd_data[3*W+5 -: W];
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
        post_count = '0; rd_ready = 1'b0; pc = '0; instr = '0;
        regwrite = 1'b0; wreg = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_state", W'(state), 0);
        chk("reset_count", W'(count), 0);
        chk("reset_rd_valid", W'(rd_valid), 0);
        chk("reset_wrapped", W'(wrapped), 0);
        retire(32'h100);
        chk("idle_no_capture_count", W'(count), 0);
        chk("idle_no_capture_state", W'(state), 0);
    endtask

    task automatic test_basic();
        logic [3*W+5:0] exp_entry;
        trig_en = 1'b1; trig_pc = 32'h10; post_count = 3'd0;
        set_retire(32'h0);
        arm = 1'b1;
        tick();
        arm = 1'b0; en = 1'b0;
        chk("basic_armed", W'(state), 1);
        chk("basic_arm_cycle_dropped", W'(count), 0);
        for (int i = 0; i < 5; i++) begin
            set_retire(32'(4 * i));
            tick();
            if (i < 4) chk("basic_still_armed", W'(state), 1);
        end
        en = 1'b0;
        chk("basic_done", W'(state), 3);
        chk("basic_count", W'(count), 5);
        chk("basic_wrapped", W'(wrapped), 0);
        retire(32'h40);
        chk("basic_done_ignores_en", W'(count), 5);
        exp_entry = {32'h0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0};
        checks++;
        if (rd_data !== exp_entry) begin
            errors++;
            $display("FAIL basic_entry0: got 0x%0h expected 0x%0h", rd_data, exp_entry);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("basic_rd_valid", W'(rd_valid), 1);
            chk("basic_drain_pc", rd_pc(), 32'(4 * i));
            tick();
        end
        rd_ready = 1'b0;
        chk("basic_idle", W'(state), 0);
        chk("basic_drained_valid", W'(rd_valid), 0);
        chk("basic_drained_count", W'(count), 0);
    endtask

    task automatic test_wrap();
        trig_en = 1'b1; trig_pc = 32'h4C; post_count = 3'd0;
        do_arm();
        for (int i = 0; i < 20; i++) begin
            set_retire(32'(4 * i));
            tick();
        end
        en = 1'b0;
        chk("wrap_done", W'(state), 3);
        chk("wrap_count", W'(count), 8);
        chk("wrap_flag", W'(wrapped), 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("wrap_drain_pc", rd_pc(), 32'h30 + 32'(4 * i));
            tick();
        end
        rd_ready = 1'b0;
        chk("wrap_idle", W'(state), 0);
    endtask

    task automatic test_post_trigger();
        trig_en = 1'b1; trig_pc = 32'h08; post_count = 3'd3;
        do_arm();
        for (int i = 0; i < 8; i++) begin
            set_retire(32'(4 * i));
            tick();
            if (i == 2) chk("post_state_post", W'(state), 2);
            if (i == 5) chk("post_done_after_0x14", W'(state), 3);
        end
        en = 1'b0;
        chk("post_done", W'(state), 3);
        chk("post_count", W'(count), 6);
        chk("post_wrapped", W'(wrapped), 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_drain_pc", rd_pc(), 32'(4 * i));
            tick();
        end
        rd_ready = 1'b0;
        chk("post_idle", W'(state), 0);
    endtask

    task automatic test_back_pressure();
        logic        ready_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] pc_seq    [6] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC};
        int          cnt_seq   [6] = '{4, 3, 3, 3, 2, 1};
        trig_en = 1'b1; trig_pc = 32'h0C; post_count = 3'd0;
        do_arm();
        for (int i = 0; i < 4; i++) retire(32'(4 * i));
        chk("bp_done", W'(state), 3);
        chk("bp_count", W'(count), 4);
        for (int i = 0; i < 6; i++) begin
            rd_ready = ready_seq[i];
            chk("bp_rd_valid", W'(rd_valid), 1);
            chk("bp_rd_pc", rd_pc(), pc_seq[i]);
            chk("bp_count_step", W'(count), W'(cnt_seq[i]));
            tick();
        end
        rd_ready = 1'b0;
        chk("bp_valid_low", W'(rd_valid), 0);
        chk("bp_idle", W'(state), 0);
    endtask

    task automatic test_restart_reset();
        trig_en = 1'b1; trig_pc = 32'h0; post_count = 3'd3;
        do_arm();
        retire(32'h0);
        retire(32'h4);
        chk("restart_in_post", W'(state), 2);
        chk("restart_pre_count", W'(count), 2);
        set_retire(32'h8);
        arm = 1'b1;
        tick();
        arm = 1'b0; en = 1'b0;
        chk("restart_armed", W'(state), 1);
        chk("restart_count", W'(count), 0);
        trig_pc = 32'h20; post_count = 3'd0;
        retire(32'h20);
        chk("restart_fresh_done", W'(state), 3);
        chk("restart_fresh_count", W'(count), 1);
        chk("restart_fresh_pc", rd_pc(), 32'h20);

        // arm beats a simultaneous pop in DONE
        rd_ready = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0; rd_ready = 1'b0;
        chk("arm_over_pop_state", W'(state), 1);
        chk("arm_over_pop_count", W'(count), 0);

        trig_pc = 32'h08;
        for (int i = 0; i < 3; i++) retire(32'(4 * i));
        chk("rst_pre_done", W'(state), 3);
        chk("rst_pre_count", W'(count), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rd_valid", W'(rd_valid), 0);
        chk("rst_count", W'(count), 0);
        chk("rst_state", W'(state), 0);
    endtask

    task automatic test_gaps();
        trig_en = 1'b0; trig_pc = 32'h0; post_count = 3'd0;
        do_arm();
        rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_retire(32'(4 * (i % 4)));
            en = (i % 2 == 0);
            tick();
        end
        en = 1'b0;
        chk("gaps_state", W'(state), 1);
        chk("gaps_count", W'(count), 6);
        chk("gaps_wrapped", W'(wrapped), 0);
        chk("gaps_rd_valid", W'(rd_valid), 0);
        for (int i = 0; i < 10; i++) begin
            set_retire(32'h0);
            tick();
        end
        en = 1'b0;
        rd_ready = 1'b0;
        chk("gaps_wrap_state", W'(state), 1);
        chk("gaps_wrap_count", W'(count), 8);
        chk("gaps_wrap_flag", W'(wrapped), 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_post_trigger();
        test_back_pressure();
        test_restart_reset();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
